// File: rtl/zap_sync_fifo_lvl_if.sv
// Handshake/data bundle for zap_sync_fifo_lvl: the producer/consumer side (master)
// and the FIFO side (slave).
interface zap_sync_fifo_lvl_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PTR_WDT = 6
);
  logic               i_wr_en;
  logic [WIDTH-1:0]   i_data;
  logic               i_ack;
  logic               i_clear;
  logic [WIDTH-1:0]   o_data;
  logic               o_empty;
  logic               o_empty_n;
  logic               o_full;
  logic               o_full_n;
  logic               o_almost_full;
  logic               o_almost_empty;
  logic [PTR_WDT-1:0] o_level;
  logic               o_overflow;
  logic               o_underflow;

  modport master (
    output i_wr_en, i_data, i_ack, i_clear,
    input  o_data, o_empty, o_empty_n, o_full, o_full_n,
           o_almost_full, o_almost_empty, o_level, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_data, i_ack, i_clear,
    output o_data, o_empty, o_empty_n, o_full, o_full_n,
           o_almost_full, o_almost_empty, o_level, o_overflow, o_underflow
  );
endinterface

// File: rtl/zap_sync_fifo_lvl.sv
// Show-ahead synchronous FIFO with registered level and watermark flags.
// Define ZAP_SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module zap_sync_fifo_lvl #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned ALMOST_FULL  = 28,
  parameter int unsigned ALMOST_EMPTY = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  zap_sync_fifo_lvl_if.slave  io_bus
);
  localparam int unsigned PTR_WDT  = $clog2(DEPTH) + 1;
  localparam int unsigned ADDR_WDT = PTR_WDT - 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_WDT-1:0] r_wr_ptr;
  logic [PTR_WDT-1:0] r_rd_ptr;
  logic [PTR_WDT-1:0] r_level;
  logic               r_empty;
  logic               r_full;
  logic               r_almost_full;
  logic               r_almost_empty;

  logic               w_read_ok;
  logic               w_write_ok;
  logic               w_flush;
  logic [PTR_WDT-1:0] w_level_nxt;

  // Accept logic: a write to a full FIFO is allowed when a pop frees a slot.
  always_comb begin
    w_flush     = i_reset | io_bus.i_clear;
    w_read_ok   = io_bus.i_ack & ~r_empty;
    w_write_ok  = io_bus.i_wr_en & (~r_full | w_read_ok);
    w_level_nxt = r_level + PTR_WDT'(w_write_ok) - PTR_WDT'(w_read_ok);
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_write_ok) r_wr_ptr <= r_wr_ptr + PTR_WDT'(1);
      if (w_read_ok)  r_rd_ptr <= r_rd_ptr + PTR_WDT'(1);
      r_level        <= w_level_nxt;
      r_empty        <= (w_level_nxt == '0);
      r_full         <= (w_level_nxt == PTR_WDT'(DEPTH));
      r_almost_full  <= (w_level_nxt >= PTR_WDT'(ALMOST_FULL));
      r_almost_empty <= (w_level_nxt <= PTR_WDT'(ALMOST_EMPTY));
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_write_ok & ~w_flush) begin
      r_mem[r_wr_ptr[ADDR_WDT-1:0]] <= io_bus.i_data;
    end
  end

  assign io_bus.o_data         = r_mem[r_rd_ptr[ADDR_WDT-1:0]];
  assign io_bus.o_empty        = r_empty;
  assign io_bus.o_empty_n      = ~r_empty;
  assign io_bus.o_full         = r_full;
  assign io_bus.o_full_n       = ~r_full;
  assign io_bus.o_almost_full  = r_almost_full;
  assign io_bus.o_almost_empty = r_almost_empty;
  assign io_bus.o_level        = r_level;

`ifdef ZAP_SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Underflow only counts a pop that was lost with no write accepted alongside it.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (io_bus.i_wr_en & ~w_write_ok)            r_overflow  <= 1'b1;
      if (io_bus.i_ack & r_empty & ~w_write_ok)    r_underflow <= 1'b1;
    end
  end

  assign io_bus.o_overflow  = r_overflow;
  assign io_bus.o_underflow = r_underflow;
`else
  assign io_bus.o_overflow  = 1'b0;
  assign io_bus.o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_zap_sync_fifo_lvl.sv
// Bench for zap_sync_fifo_lvl: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_zap_sync_fifo_lvl;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned AF      = 28;
  localparam int unsigned AE      = 4;
  localparam int unsigned PTR_WDT = $clog2(DEPTH) + 1;
`ifdef ZAP_SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic i_clk;
  logic i_reset;

  zap_sync_fifo_lvl_if #(.WIDTH(WIDTH), .PTR_WDT(PTR_WDT)) bus ();

  zap_sync_fifo_lvl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .io_bus (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: FIFO occupancy is just the queue length.
  task automatic model_edge(input bit rst, input bit clr, input bit wr,
                            input logic [WIDTH-1:0] d, input bit ack);
    bit rd_ok, wr_ok;
    if (rst || clr) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = ack && (m_q.size() > 0);
      wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (ack && (m_q.size() == 0) && !wr_ok) m_unf = 1'b1;
      if (rd_ok) void'(m_q.pop_front());
      if (wr_ok) m_q.push_back(d);
    end
  endtask

  task automatic check_all();
    int unsigned lvl;
    lvl = m_q.size();
    check_val("level", 64'(bus.o_level), 64'(lvl));
    check_val("empty", 64'(bus.o_empty), 64'(lvl == 0));
    check_val("empty_n", 64'(bus.o_empty_n), 64'(lvl != 0));
    check_val("full", 64'(bus.o_full), 64'(lvl == DEPTH));
    check_val("full_n", 64'(bus.o_full_n), 64'(lvl != DEPTH));
    check_val("almost_full", 64'(bus.o_almost_full), 64'(lvl >= AF));
    check_val("almost_empty", 64'(bus.o_almost_empty), 64'(lvl <= AE));
    check_val("overflow", 64'(bus.o_overflow), 64'(ERR_EN & m_ovf));
    check_val("underflow", 64'(bus.o_underflow), 64'(ERR_EN & m_unf));
    if (lvl != 0) check_val("data", 64'(bus.o_data), 64'(m_q[0]));
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
  task automatic cyc(input bit rst, input bit clr, input bit wr,
                     input logic [WIDTH-1:0] d, input bit ack);
    i_reset     = rst;
    bus.i_clear = clr;
    bus.i_wr_en = wr;
    bus.i_data  = d;
    bus.i_ack   = ack;
    @(posedge i_clk);
    model_edge(rst, clr, wr, d, ack);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] pat;
    int unsigned      wr_pct;
    int unsigned      ack_pct;
    bit               r_wr;
    bit               r_ack;
    i_reset     = 1'b1;
    bus.i_clear = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_data  = '0;
    bus.i_ack   = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_val("reset_level", 64'(bus.o_level), 64'd0);
    idle();

    // Four writes then four pops, head data follows write order.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(32'hA0 + i), 1'b0);
    check_val("lvl4", 64'(bus.o_level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("head_a", 64'(bus.o_data), 64'(32'hA0 + i));
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end

    // Fill to full, overflow attempt, then write-through at full.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0, 1'b1, WIDTH'(32'h100 + i), 1'b0);
      check_val("af_edge", 64'(bus.o_almost_full), 64'(i >= 27));
      check_val("full_edge", 64'(bus.o_full), 64'(i == 31));
    end
    cyc(1'b0, 1'b0, 1'b1, WIDTH'(32'hDEAD), 1'b0);
    check_val("ovf_level", 64'(bus.o_level), 64'd32);
    cyc(1'b0, 1'b0, 1'b1, WIDTH'(32'h55), 1'b1);
    check_val("wt_full", 64'(bus.o_full), 64'd1);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check_val("last_55", 64'(bus.o_data), 64'h55);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end

    // Simultaneous pop and write on empty: only the write lands.
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, WIDTH'(32'h77), 1'b1);
    check_val("emp_rw_data", 64'(bus.o_data), 64'h77);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Clear wins over read and write at level 10.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, WIDTH'(32'hBEEF), 1'b1);
    check_val("clr_level", 64'(bus.o_level), 64'd0);
    idle();

    // Pointer wrap at steady level 3.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b0);
    for (int i = 3; i < 103; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b1);
    check_val("wrap_level", 64'(bus.o_level), 64'd3);
    check_val("wrap_head", 64'(bus.o_data), 64'd100);

    // Reset mid-operation discards the concurrent write.
    cyc(1'b1, 1'b0, 1'b1, WIDTH'(32'h99), 1'b0);

    // Random traffic, biased in phases to sweep empty through full.
    pat = '0;
    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0:       begin wr_pct = 85; ack_pct = 20; end
        1:       begin wr_pct = 20; ack_pct = 85; end
        default: begin wr_pct = 60; ack_pct = 60; end
      endcase
      for (int c = 0; c < 200; c++) begin
        r_wr  = ($urandom_range(99) < wr_pct);
        r_ack = ($urandom_range(99) < ack_pct);
        pat   = WIDTH'($urandom);
        cyc(($urandom_range(499) == 0), ($urandom_range(149) == 0), r_wr, pat, r_ack);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
